// File: rtl/cpu_pkg.sv
// Shared CPU decode definitions: immediate-type encoding and RV32 major opcodes.
package cpu_pkg;

    typedef enum logic [2:0] {
        I_IMM = 3'b000,
        S_IMM = 3'b001,
        B_IMM = 3'b010,
        U_IMM = 3'b011,
        J_IMM = 3'b100
    } imm_type_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_type_decode.sv
// Combinational opcode classifier feeding the immediate generator.
// IMM_DECODE_ILLEGAL_TRAP_EN: flag unknown opcodes as illegal instead of treating them as I-type.
module imm_type_decode
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_type,
    output logic       uses_imm,
    output logic       illegal
);

    always_comb begin
        imm_type = I_IMM;
        uses_imm = 1'b1;
        illegal  = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: imm_type = I_IMM;
            OPC_STORE:                                 imm_type = S_IMM;
            OPC_BRANCH:                                imm_type = B_IMM;
            OPC_LUI, OPC_AUIPC:                        imm_type = U_IMM;
            OPC_JAL:                                   imm_type = J_IMM;
            OPC_OP:                                    uses_imm = 1'b0;
            default: begin
`ifdef IMM_DECODE_ILLEGAL_TRAP_EN
                uses_imm = 1'b0;
                illegal  = 1'b1;
`else
                uses_imm = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Decode-stage 2-entry skid buffer with per-entry registered immediate-type decode.
// IMM_DECODE_ILLEGAL_TRAP_EN (in imm_type_decode) enables the illegal-opcode flag.
module imm_decode_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RST_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [2:0]      imm_type,
    output logic            uses_imm,
    output logic            illegal
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e          state;
    logic [XLEN-1:0] tail_inst;
    logic [XLEN-1:0] tail_pc;
    logic [2:0]      tail_type;
    logic            tail_uses;
    logic            tail_illegal;

    logic [2:0] dec_type;
    logic       dec_uses;
    logic       dec_illegal;
    logic       accept;
    logic       pop;

    // Decode at the write side so every entry carries its own classification.
    imm_type_decode u_imm_type_decode (
        .opcode   (if_inst[6:0]),
        .imm_type (dec_type),
        .uses_imm (dec_uses),
        .illegal  (dec_illegal)
    );

    assign accept = if_valid & if_ready;
    assign pop    = id_valid & id_ready;

    // Head entry lives directly in the output registers; an empty head shows the NOP word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StEmpty;
            if_ready     <= 1'b1;
            id_valid     <= 1'b0;
            id_inst      <= RST_INST;
            id_pc        <= '0;
            imm_type     <= I_IMM;
            uses_imm     <= 1'b0;
            illegal      <= 1'b0;
            tail_inst    <= RST_INST;
            tail_pc      <= '0;
            tail_type    <= I_IMM;
            tail_uses    <= 1'b0;
            tail_illegal <= 1'b0;
        end else if (flush) begin
            state    <= StEmpty;
            if_ready <= 1'b1;
            id_valid <= 1'b0;
            id_inst  <= RST_INST;
            id_pc    <= '0;
            imm_type <= I_IMM;
            uses_imm <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                StEmpty: begin
                    if (accept) begin
                        state    <= StOne;
                        id_valid <= 1'b1;
                        id_inst  <= if_inst;
                        id_pc    <= if_pc;
                        imm_type <= dec_type;
                        uses_imm <= dec_uses;
                        illegal  <= dec_illegal;
                    end
                end
                StOne: begin
                    if (accept && !pop) begin
                        state        <= StTwo;
                        if_ready     <= 1'b0;
                        tail_inst    <= if_inst;
                        tail_pc      <= if_pc;
                        tail_type    <= dec_type;
                        tail_uses    <= dec_uses;
                        tail_illegal <= dec_illegal;
                    end else if (pop && !accept) begin
                        state    <= StEmpty;
                        id_valid <= 1'b0;
                        id_inst  <= RST_INST;
                        id_pc    <= '0;
                        imm_type <= I_IMM;
                        uses_imm <= 1'b0;
                        illegal  <= 1'b0;
                    end else if (pop && accept) begin
                        id_inst  <= if_inst;
                        id_pc    <= if_pc;
                        imm_type <= dec_type;
                        uses_imm <= dec_uses;
                        illegal  <= dec_illegal;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        state    <= StOne;
                        if_ready <= 1'b1;
                        id_inst  <= tail_inst;
                        id_pc    <= tail_pc;
                        imm_type <= tail_type;
                        uses_imm <= tail_uses;
                        illegal  <= tail_illegal;
                    end
                end
                default: state <= StEmpty;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Self-checking bench for imm_decode_ctrl: directed scenarios plus a randomized queue-model run.
module tb_imm_decode_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_inst = '0;
    logic [31:0] if_pc = '0;
    logic        flush = 1'b0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [2:0]  imm_type;
    logic        uses_imm;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    imm_decode_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_inst  (if_inst),
        .if_pc    (if_pc),
        .flush    (flush),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_inst  (id_inst),
        .id_pc    (id_pc),
        .imm_type (imm_type),
        .uses_imm (uses_imm),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Reference classification table: {imm_type, uses_imm, illegal}.
    function automatic logic [4:0] ref_decode(input logic [31:0] inst);
        case (inst[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: return {3'd0, 1'b1, 1'b0};
            7'h23:                      return {3'd1, 1'b1, 1'b0};
            7'h63:                      return {3'd2, 1'b1, 1'b0};
            7'h37, 7'h17:               return {3'd3, 1'b1, 1'b0};
            7'h6F:                      return {3'd4, 1'b1, 1'b0};
            7'h33:                      return {3'd0, 1'b0, 1'b0};
`ifdef IMM_DECODE_ILLEGAL_TRAP_EN
            default:                    return {3'd0, 1'b0, 1'b1};
`else
            default:                    return {3'd0, 1'b1, 1'b0};
`endif
        endcase
    endfunction

    task automatic offer(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        if_valid = v;
        if_inst  = inst;
        if_pc    = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready got=%0b exp=1", if_ready); end
        checks++; if (id_inst !== NOP) begin failures++; $display("FAIL reset_id_inst got=%h exp=%h", id_inst, NOP); end
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
        checks++; if ({imm_type, uses_imm, illegal} !== 5'b0) begin failures++; $display("FAIL reset_decode got=%b exp=00000", {imm_type, uses_imm, illegal}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        id_ready = 1'b1;
        offer(1'b1, 32'h0050_0093, 32'h100);
        @(negedge clk);
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL stream_valid got=%0b exp=1", id_valid); end
        checks++; if (id_inst !== 32'h0050_0093) begin failures++; $display("FAIL stream_addi_inst got=%h exp=00500093", id_inst); end
        checks++; if ({imm_type, uses_imm} !== 4'b0001) begin failures++; $display("FAIL stream_addi_dec got=%b exp=0001", {imm_type, uses_imm}); end
        offer(1'b1, 32'h0011_2023, 32'h104);
        @(negedge clk);
        checks++; if (id_inst !== 32'h0011_2023) begin failures++; $display("FAIL stream_sw_inst got=%h exp=00112023", id_inst); end
        checks++; if (imm_type !== 3'b001) begin failures++; $display("FAIL stream_sw_type got=%b exp=001", imm_type); end
        offer(1'b0, '0, '0);
        @(negedge clk);
        checks++; if (id_valid !== 1'b0 || id_inst !== NOP) begin failures++; $display("FAIL stream_drain got=%0b/%h exp=0/%h", id_valid, id_inst, NOP); end
    endtask

    task automatic test_backpressure();
        id_ready = 1'b0;
        offer(1'b1, 32'h0000_0113, 32'h200);
        @(negedge clk);
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%0b exp=1", if_ready); end
        offer(1'b1, 32'h0000_0193, 32'h204);
        @(negedge clk);
        checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_two got=%0b exp=0", if_ready); end
        offer(1'b1, 32'h0000_0213, 32'h208);
        @(negedge clk);
        checks++; if (if_ready !== 1'b0 || id_pc !== 32'h200) begin failures++; $display("FAIL bp_hold got=%0b/%h exp=0/200", if_ready, id_pc); end
        id_ready = 1'b1;
        @(negedge clk);
        checks++; if (id_inst !== 32'h0000_0193 || id_pc !== 32'h204) begin failures++; $display("FAIL bp_pop2 got=%h/%h exp=00000193/204", id_inst, id_pc); end
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%0b exp=1", if_ready); end
        @(negedge clk);
        checks++; if (id_inst !== 32'h0000_0213 || id_pc !== 32'h208) begin failures++; $display("FAIL bp_pop3 got=%h/%h exp=00000213/208", id_inst, id_pc); end
        offer(1'b0, '0, '0);
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b exp=0", id_valid); end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        offer(1'b1, 32'h0000_0113, 32'h300);
        @(negedge clk);
        offer(1'b1, 32'h0000_0193, 32'h304);
        @(negedge clk);
        checks++; if (if_ready !== 1'b0 || id_valid !== 1'b1) begin failures++; $display("FAIL flush_pre got=%0b/%0b exp=0/1", if_ready, id_valid); end
        flush = 1'b1;
        offer(1'b1, 32'h0000_006F, 32'h308);
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", id_valid); end
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b exp=1", if_ready); end
        checks++; if (id_inst !== NOP || imm_type !== 3'b000 || uses_imm !== 1'b0) begin failures++; $display("FAIL flush_head got=%h/%b/%0b exp=%h/000/0", id_inst, imm_type, uses_imm, NOP); end
        flush = 1'b0;
        offer(1'b0, '0, '0);
        id_ready = 1'b1;
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost got=%0b exp=0", id_valid); end
    endtask

    task automatic test_opcodes();
        logic [31:0] words [4] = '{32'hFE00_0EE3, 32'h0000_12B7, 32'h0080_00EF, 32'h0020_81B3};
        logic [3:0]  expd  [4] = '{4'b0101, 4'b0111, 4'b1001, 4'b0000};
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, words[i], 32'h400 + 32'(i * 4));
            @(negedge clk);
            checks++;
            if (id_inst !== words[i] || {imm_type, uses_imm} !== expd[i]) begin
                failures++;
                $display("FAIL opcode_%0d got=%h/%b exp=%h/%b", i, id_inst, {imm_type, uses_imm}, words[i], expd[i]);
            end
        end
        offer(1'b0, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_illegal();
        id_ready = 1'b1;
        offer(1'b1, 32'h0000_007F, 32'h500);
        @(negedge clk);
`ifdef IMM_DECODE_ILLEGAL_TRAP_EN
        checks++; if ({imm_type, uses_imm, illegal} !== 5'b00001) begin failures++; $display("FAIL illegal_trap got=%b exp=00001", {imm_type, uses_imm, illegal}); end
`else
        checks++; if ({imm_type, uses_imm, illegal} !== 5'b00010) begin failures++; $display("FAIL illegal_itype got=%b exp=00010", {imm_type, uses_imm, illegal}); end
`endif
        offer(1'b0, '0, '0);
        @(negedge clk);
        checks++; if (id_valid !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL illegal_pop got=%0b/%0b exp=0/0", id_valid, illegal); end
    endtask

    task automatic test_random();
        ent_t        q[$];
        logic [6:0]  opcs [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                                   7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
        logic [4:0]  ex;
        logic [31:0] r;
        logic [31:0] pc = 32'h1000;
        logic        v, rdy, fl, acc, pp;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            checks++; if (if_ready !== (q.size() < 2)) begin failures++; $display("FAIL rand_if_ready cyc=%0d got=%0b exp=%0b", i, if_ready, q.size() < 2); end
            checks++; if (id_valid !== (q.size() > 0)) begin failures++; $display("FAIL rand_id_valid cyc=%0d got=%0b exp=%0b", i, id_valid, q.size() > 0); end
            if (q.size() > 0) begin
                ex = ref_decode(q[0].inst);
                checks++;
                if (id_inst !== q[0].inst || id_pc !== q[0].pc || {imm_type, uses_imm, illegal} !== ex) begin
                    failures++;
                    $display("FAIL rand_head cyc=%0d got=%h/%h/%b exp=%h/%h/%b", i, id_inst, id_pc,
                             {imm_type, uses_imm, illegal}, q[0].inst, q[0].pc, ex);
                end
            end else begin
                checks++;
                if (id_inst !== NOP || {imm_type, uses_imm, illegal} !== 5'b0) begin
                    failures++;
                    $display("FAIL rand_empty cyc=%0d got=%h/%b exp=%h/00000", i, id_inst, {imm_type, uses_imm, illegal}, NOP);
                end
            end
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            r   = $urandom();
            pc  = pc + 32'd4;
            offer(v, {r[31:7], opcs[$urandom_range(0, 10)]}, pc);
            id_ready = rdy;
            flush    = fl;
            acc = v && (q.size() < 2);
            pp  = rdy && (q.size() > 0);
            if (fl) begin
                q.delete();
            end else begin
                if (pp) void'(q.pop_front());
                if (acc) q.push_back('{inst: if_inst, pc: if_pc});
            end
            @(negedge clk);
        end
        flush = 1'b0;
        offer(1'b0, '0, '0);
        id_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        id_ready = 1'b0;
        offer(1'b1, 32'h0000_0113, 32'h600);
        @(negedge clk);
        offer(1'b1, 32'h0000_0193, 32'h604);
        @(negedge clk);
        offer(1'b0, '0, '0);
        checks++; if (if_ready !== 1'b0 || id_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%0b/%0b exp=0/1", if_ready, id_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL arst_id_valid got=%0b exp=0", id_valid); end
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL arst_if_ready got=%0b exp=1", if_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        id_ready = 1'b1;
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL arst_no_replay got=%0b exp=0", id_valid); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_opcodes();
        test_illegal();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
